// File: rtl/arb_grant_queue.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant_queue
// Description : Captures the payload and encoded index of the client granted
//               by rr_arbiter into a small in-order FIFO. The FIFO drains
//               through a valid/ready port. When it is full, the block stalls
//               the arbiter so that no granted request is lost.
// Revision    : 1.0  initial release
// ============================================================================
module arb_grant_queue #(
  parameter int CLIENTS = 32,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int IDX_W   = $clog2(CLIENTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CLIENTS-1:0]          grant,
  input  logic [CLIENTS*DATA_W-1:0]   req_data,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_client,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        onehot_err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [DATA_W-1:0]  r_mem_data   [DEPTH];
  logic [IDX_W-1:0]   r_mem_client [DEPTH];
  logic               r_onehot_err;

  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_data;
  logic               w_multi;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  // Lowest-set-bit encode of the grant, selecting that client's payload.
  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    w_idx  = '0;
    w_data = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (grant[i]) begin
        w_idx  = IDX_W'(i);
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // More than one grant bit set: clearing the lowest set bit leaves something.
  assign w_multi = |(grant & (grant - CLIENTS'(1)));

  // Stall depends on registered occupancy only, keeping grant and out_ready
  // out of the arbiter's stall timing path.
  assign w_full = (r_count == c_FULL);
  assign w_push = (|grant) && !w_full;
  assign w_pop  = out_valid && out_ready;

  // Storage and pointer update; reset discards every entry immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i]   <= '0;
        r_mem_client[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr]   <= w_data;
        r_mem_client[r_wr_ptr] <= w_idx;
        r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle error pulse for an accepted grant that was not one-hot.
  // Grants ignored during stall are never flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_onehot_err <= 1'b0;
    end else begin
      r_onehot_err <= w_push && w_multi;
    end
  end

  assign stall      = w_full;
  assign count      = r_count;
  assign onehot_err = r_onehot_err;
  assign out_valid  = (r_count != '0);
  // Head entry comes straight from registered storage; zero while empty.
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr]   : '0;
  assign out_client = out_valid ? r_mem_client[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: doc/arb_grant_queue.md
Name: arb_grant_queue

Overview:
- Stage directly downstream of rr_arbiter. It consumes the arbiter's one-hot grant vector and captures the granted client's payload together with its encoded client index.
- Captured entries go into a small in-order FIFO, which drains through a valid/ready output port.
- When the FIFO is full, the block drives the arbiter's stall input, so granted requests are never dropped.

Parameters:
- CLIENTS, 32, number of arbiter clients; must be >= 2.
- DATA_W, 8, payload width per client.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- IDX_W, $clog2(CLIENTS), width of the encoded client index (derived).

Ports:
- clock  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- grant  in  CLIENTS  one-hot grant from rr_arbiter; bit i = client i granted this cycle.
- req_data  in  CLIENTS*DATA_W  client payloads; client i occupies bits [i*DATA_W +: DATA_W].
- stall  out  1  to rr_arbiter stall input; high means the arbiter must hold off and grant is ignored.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry when out_valid && out_ready.
- out_data  out  DATA_W  head entry payload.
- out_client  out  IDX_W  head entry client index.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- onehot_err  out  1  registered one-cycle pulse; an accepted grant had more than one bit set.

Behaviour:
- Reset (reset=1 at posedge):
  - count=0, write/read pointers=0, out_valid=0, onehot_err=0, stall=0.
  - out_data and out_client read as 0 while empty.
  - Reset mid-operation discards all entries immediately.
- stall:
  - Combinational from registered count: stall = (count == DEPTH).
  - No combinational path from out_ready or grant to stall.
- push:
  - push = (grant != 0) && !stall.
  - A grant present while stall=1 is ignored. It is not queued and not flagged, because the arbiter guarantees it re-presents the request.
- Index encode:
  - out_client is the index of the lowest set bit of grant; the payload is req_data of that index.
  - If popcount(grant) > 1 on a push, the entry still uses the lowest set bit, and onehot_err=1 in the following cycle only.
- pop: pop = out_valid && out_ready.
- Occupancy and validity:
  - out_valid = (count != 0).
  - out_data/out_client are driven from the read-pointer entry, which is registered storage. There is no combinational bypass.
- Latency: grant accepted in cycle t produces out_valid in cycle t+1 at the earliest, when the FIFO was empty.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, write and read both advance.
  - Push and pop together is legal at every occupancy below DEPTH, including 0. At 0 the pop is impossible because out_valid=0, so only the push takes effect.
- Full: at count == DEPTH, stall=1 and push=0. A pop in that cycle lowers count to DEPTH-1, and stall deasserts the next cycle.
- Empty: out_ready while empty has no effect and count stays 0.
- Pointers:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Ordering is strict FIFO in push order.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_client stay stable.
- Invariants (checked as assertions in the bench):
  - count <= DEPTH.
  - stall implies count == DEPTH.
  - No write occurs while count == DEPTH without a simultaneous pop.
  - Every entry pushed is popped exactly once, unless reset intervenes.

Test Plan:
- Single grant: reset, then grant=32'h0000_0010 with req_data[4]=8'hA5 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_client=4, out_data=8'hA5; following cycle out_valid=0, count=0.
- Fill and stall: out_ready=0, grants to clients 0,1,2,3 in consecutive cycles -> count=4 and stall=1 after the 4th; grant to client 5 during stall is ignored. Then set out_ready=1 -> pops in order 0,1,2,3, client 5 never appears, stall drops the cycle after the first pop.
- Simultaneous push/pop at count=2: grant client 7 with out_ready=1 -> count stays 2, head advances to the next older entry, client 7 appears last.
- Pointer wrap: stream 10 grants to clients 0..9 with out_ready toggling 1,0,1,0 -> outputs 0..9 in order, no loss, count never exceeds 4.
- Multi-hot: grant=32'h0000_0006 -> entry out_client=1, onehot_err=1 for exactly one cycle.
- Reset mid-operation: count=3, assert reset for 1 cycle -> count=0, out_valid=0, stall=0, onehot_err=0 on the next cycle; stale entries never emerge.
